// File: rtl/l1_i_pkg.sv
`default_nettype none
// ============================================================================
// l1_i_pkg : shared widths, line geometry and refill FSM encodings for L1-I
// Rev 1.0
// ============================================================================
package l1_i_pkg;

  localparam int TAG_W      = 20;
  localparam int IDX_W      = 6;
  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 16;
  localparam int OFF_W      = $clog2(LINE_WORDS);
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int ADDR_W     = 32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WB   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [TAG_W-1:0] t,
                                                  input logic [IDX_W-1:0] i,
                                                  input logic [OFF_W-1:0] b);
    return {t, i, b, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/l1_i_refill_unit_if.sv
`default_nettype none
// ============================================================================
// l1_i_refill_unit_if : single-word req/gnt/rvalid memory beat bus
// Rev 1.0
// ============================================================================
interface l1_i_refill_unit_if
  import l1_i_pkg::*;
();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/l1_i_line_buffer.sv
`default_nettype none
// ============================================================================
// l1_i_line_buffer : LINE_WORDS x WORD_W register line, word write, flat read
// Rev 1.0
// ============================================================================
module l1_i_line_buffer
  import l1_i_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  wr_word,
  input  logic [WORD_W-1:0] wr_data,
  output logic [LINE_W-1:0] line
);

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_word
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_word <= '0;
      end else if (wr_en && (wr_word == OFF_W'(g))) begin
        r_word <= wr_data;
      end
    end

    assign line[g*WORD_W +: WORD_W] = r_word;
  end

endmodule
`default_nettype wire

// File: rtl/l1_i_refill_unit.sv
`default_nettype none
// ============================================================================
// l1_i_refill_unit : L1-I line fill / victim write-back engine on a beat bus
// Optional: L1I_REFILL_PERF_EN adds fill/write-back/busy-cycle counters
// Rev 1.0
// ============================================================================
module l1_i_refill_unit
  import l1_i_pkg::*;
(
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       read_L1_L2,
  input  logic                       write_L1_L2,
  input  logic [TAG_W-1:0]           tag,
  input  logic [IDX_W-1:0]           index,
  input  logic [TAG_W-1:0]           wb_tag,
  input  logic [LINE_W-1:0]          wb_line,
  output logic                       ready_L2_L1,
  output logic [LINE_W-1:0]          refill_line,
`ifdef L1I_REFILL_PERF_EN
  output logic [31:0]                fill_cnt,
  output logic [31:0]                wb_cnt,
  output logic [31:0]                stall_cyc_cnt,
`endif
  l1_i_refill_unit_if.master         mem
);

  logic [2:0]        r_state;
  logic [OFF_W-1:0]  r_req_cnt;
  logic [OFF_W-1:0]  r_rsp_cnt;
  logic              r_req_done;
  logic              r_is_fill;
  logic [TAG_W-1:0]  r_tag;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] w_line;

  logic w_in_wb;
  logic w_in_rd;
  logic w_fire;
  logic w_rsp;
  logic w_last_req;
  logic w_last_rsp;

  always_comb begin
    w_in_wb    = (r_state == S_WB);
    w_in_rd    = (r_state == S_RD);
    w_fire     = mem.mem_req && mem.mem_gnt;
    w_rsp      = w_in_rd && mem.mem_rvalid;
    w_last_req = (r_req_cnt == OFF_W'(LINE_WORDS - 1));
    w_last_rsp = (r_rsp_cnt == OFF_W'(LINE_WORDS - 1));
  end

  // Address fields are captured at request time so a requester dropping its
  // request mid-transfer cannot disturb the remaining beat addresses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_req_cnt  <= '0;
      r_rsp_cnt  <= '0;
      r_req_done <= 1'b0;
      r_is_fill  <= 1'b0;
      r_tag      <= '0;
      r_idx      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (write_L1_L2) begin
            r_state    <= S_WB;
            r_is_fill  <= 1'b0;
            r_tag      <= wb_tag;
            r_idx      <= index;
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_req_done <= 1'b0;
          end else if (read_L1_L2) begin
            r_state    <= S_RD;
            r_is_fill  <= 1'b1;
            r_tag      <= tag;
            r_idx      <= index;
            r_req_cnt  <= '0;
            r_rsp_cnt  <= '0;
            r_req_done <= 1'b0;
          end
        end
        S_WB: begin
          if (w_fire) begin
            r_req_cnt <= r_req_cnt + 1'b1;
            if (w_last_req) begin
              r_state <= S_DONE;
            end
          end
        end
        S_RD: begin
          if (w_fire) begin
            r_req_cnt <= r_req_cnt + 1'b1;
            if (w_last_req) begin
              r_req_done <= 1'b1;
            end
          end
          if (w_rsp) begin
            r_rsp_cnt <= r_rsp_cnt + 1'b1;
            if (w_last_rsp) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_HOLD;
        S_HOLD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  l1_i_line_buffer u_line_buffer (
    .clk     (clk),
    .nrst    (nrst),
    .wr_en   (w_rsp),
    .wr_word (r_rsp_cnt),
    .wr_data (mem.mem_rdata),
    .line    (w_line)
  );

  always_comb begin
    mem.mem_req   = w_in_wb || (w_in_rd && !r_req_done);
    mem.mem_we    = w_in_wb;
    mem.mem_addr  = (w_in_wb || w_in_rd) ? beat_addr(r_tag, r_idx, r_req_cnt) : '0;
    mem.mem_wdata = w_in_wb ? wb_line[r_req_cnt*WORD_W +: WORD_W] : '0;
    ready_L2_L1   = (r_state == S_DONE);
    refill_line   = (ready_L2_L1 && r_is_fill) ? w_line : '0;
  end

`ifdef L1I_REFILL_PERF_EN
  logic [31:0] r_fill_cnt;
  logic [31:0] r_wb_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fill_cnt  <= '0;
      r_wb_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (ready_L2_L1 && r_is_fill && (r_fill_cnt != 32'hFFFF_FFFF)) begin
        r_fill_cnt <= r_fill_cnt + 32'd1;
      end
      if (ready_L2_L1 && !r_is_fill && (r_wb_cnt != 32'hFFFF_FFFF)) begin
        r_wb_cnt <= r_wb_cnt + 32'd1;
      end
      if ((r_state != S_IDLE) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fill_cnt      = r_fill_cnt;
  assign wb_cnt        = r_wb_cnt;
  assign stall_cyc_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l1_i_refill_unit.sv
`default_nettype none
// ============================================================================
// tb_l1_i_refill_unit : randomized bench with a beat-bus memory responder and
// a line-level expectation model; optional L1I_REFILL_PERF_EN counter checks
// Rev 1.0
// ============================================================================
module tb_l1_i_refill_unit;
  import l1_i_pkg::*;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              read_L1_L2 = 1'b0;
  logic              write_L1_L2 = 1'b0;
  logic [TAG_W-1:0]  tag = '0;
  logic [IDX_W-1:0]  index = '0;
  logic [TAG_W-1:0]  wb_tag = '0;
  logic [LINE_W-1:0] wb_line = '0;
  logic              ready_L2_L1;
  logic [LINE_W-1:0] refill_line;
`ifdef L1I_REFILL_PERF_EN
  logic [31:0]       fill_cnt;
  logic [31:0]       wb_cnt;
  logic [31:0]       stall_cyc_cnt;
`endif

  l1_i_refill_unit_if bus ();

  l1_i_refill_unit dut (
    .clk           (clk),
    .nrst          (nrst),
    .read_L1_L2    (read_L1_L2),
    .write_L1_L2   (write_L1_L2),
    .tag           (tag),
    .index         (index),
    .wb_tag        (wb_tag),
    .wb_line       (wb_line),
    .ready_L2_L1   (ready_L2_L1),
    .refill_line   (refill_line),
`ifdef L1I_REFILL_PERF_EN
    .fill_cnt      (fill_cnt),
    .wb_cnt        (wb_cnt),
    .stall_cyc_cnt (stall_cyc_cnt),
`endif
    .mem           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Responder configuration and beat log
  int          gnt_mode = 0;     // 0 always, 1 toggle, 2 random
  int          rv_min = 1;
  int          rv_max = 1;
  bit          pat_mode = 1'b1;
  bit          stray_req = 1'b0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  bit          log_we[$];
  int          log_cyc[$];
  int          pend_due[$];
  logic [31:0] pend_addr[$];
  int          last_due = 0;
  int          last_rv_cyc = 0;

  int exp_fill = 0;
  int exp_wb = 0;
  int exp_stall = 0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (pat_mode) return 32'(a[5:2]) * 32'h1111_1111;
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  initial begin
    logic        g;
    logic        prev_stall;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_we;
    int          due;
    g = 1'b0;
    prev_stall = 1'b0;
    p_addr = '0;
    p_wdata = '0;
    p_we = 1'b0;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (prev_stall && nrst) begin
        chk("hold_req", bus.mem_req, 1'b1);
        chk("hold_addr", bus.mem_addr, p_addr);
        chk("hold_we", bus.mem_we, p_we);
        chk("hold_wdata", bus.mem_wdata, p_wdata);
      end
      case (gnt_mode)
        0:       g = 1'b1;
        1:       g = ~g;
        default: g = 1'($urandom_range(0, 1));
      endcase
      bus.mem_gnt = g;
      if (bus.mem_req && g) begin
        log_addr.push_back(bus.mem_addr);
        log_wdata.push_back(bus.mem_wdata);
        log_we.push_back(bus.mem_we);
        log_cyc.push_back(cyc);
        if (!bus.mem_we) begin
          due = cyc + int'($urandom_range(rv_min, rv_max));
          if (due < last_due) due = last_due;
          last_due = due;
          pend_due.push_back(due);
          pend_addr.push_back(bus.mem_addr);
        end
      end
      prev_stall = bus.mem_req && !g;
      p_addr = bus.mem_addr;
      p_wdata = bus.mem_wdata;
      p_we = bus.mem_we;
      if (stray_req) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        stray_req = 1'b0;
      end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = memfn(pend_addr[0]);
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
        last_rv_cyc = cyc;
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wdata.delete();
    log_we.delete();
    log_cyc.delete();
  endtask

  task automatic wait_ready(output int rcyc, output logic [LINE_W-1:0] line);
    rcyc = -1;
    line = '0;
    for (int n = 0; n < 400; n++) begin
      step();
      if (ready_L2_L1) begin
        rcyc = cyc;
        line = refill_line;
        return;
      end
    end
    chk("ready_seen", ready_L2_L1, 1'b1);
  endtask

  task automatic check_beats(input bit wb, input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix);
    chk("beat_count", log_addr.size(), LINE_WORDS);
    for (int k = 0; k < LINE_WORDS && k < log_addr.size(); k++) begin
      logic [31:0] ea;
      ea = (32'(t) << 12) | (32'(ix) << 6) | (32'(k) << 2);
      chk("beat_addr", log_addr[k], ea);
      chk("beat_we", log_we[k], wb);
      if (wb) chk("beat_wdata", log_wdata[k], wb_line[k*WORD_W +: WORD_W]);
    end
    clear_log();
  endtask

  task automatic check_line(input logic [TAG_W-1:0] t, input logic [IDX_W-1:0] ix,
                            input logic [LINE_W-1:0] line);
    for (int k = 0; k < LINE_WORDS; k++) begin
      logic [31:0] ea;
      ea = (32'(t) << 12) | (32'(ix) << 6) | (32'(k) << 2);
      chk("line_word", line[k*WORD_W +: WORD_W], memfn(ea));
    end
  endtask

  int t_ready = 0;
  int g_span = 0;
  logic [LINE_W-1:0] last_line = '0;

  task automatic txn(input bit wb, output int lat);
    logic [TAG_W-1:0]  t;
    logic [IDX_W-1:0]  ix;
    int                c0;
    int                rcyc;
    logic [LINE_W-1:0] line;
    t = wb ? wb_tag : tag;
    ix = index;
    clear_log();
    c0 = cyc;
    if (wb) write_L1_L2 = 1'b1;
    else    read_L1_L2 = 1'b1;
    wait_ready(rcyc, line);
    write_L1_L2 = 1'b0;
    read_L1_L2 = 1'b0;
    lat = rcyc - c0;
    t_ready = rcyc;
    last_line = line;
    g_span = (log_cyc.size() != 0) ? (log_cyc[log_cyc.size()-1] - log_cyc[0]) : -1;
    if (rcyc >= 0) begin
      check_beats(wb, t, ix);
      if (!wb) check_line(t, ix, line);
      if (wb) exp_wb++;
      else    exp_fill++;
      exp_stall += lat + 1;
    end
    step();
    chk("ready_one_cycle", ready_L2_L1, 1'b0);
    chk("hold_no_req", bus.mem_req, 1'b0);
    step();
  endtask

  task automatic rand_line();
    for (int k = 0; k < LINE_WORDS; k++) wb_line[k*WORD_W +: WORD_W] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int r1;
    int r2;
    int found;
    logic [LINE_W-1:0] line;

    // Reset state
    repeat (3) step();
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_ready", ready_L2_L1, 1'b0);
    chk("rst_line", 64'(|refill_line), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_we", bus.mem_we, 1'b0);
    nrst = 1'b1;
    step();

    // Ideal fill, pattern data
    gnt_mode = 0; rv_min = 1; rv_max = 1; pat_mode = 1'b1;
    tag = 20'hABCDE; index = 6'd5;
    txn(1'b0, lat);
    chk("fill_latency", lat, LINE_WORDS + 2);
`ifdef L1I_REFILL_PERF_EN
    chk("perf_fill_one", fill_cnt, 1);
`endif

    // Write-back with toggling grant, then ideal write-back latency
    gnt_mode = 1; wb_tag = 20'h12345; index = 6'd63; rand_line();
    txn(1'b1, lat);
    gnt_mode = 0; rand_line();
    txn(1'b1, lat);
    chk("wb_latency", lat, LINE_WORDS + 1);

    // Both requests: write-back first, HOLD ignores the still-set read
    tag = 20'h0F0F0; wb_tag = 20'h7A5A5; index = 6'd17; rand_line();
    clear_log();
    r1 = cyc;
    write_L1_L2 = 1'b1; read_L1_L2 = 1'b1;
    wait_ready(r2, line);
    write_L1_L2 = 1'b0;
    if (r2 >= 0) begin
      check_beats(1'b1, wb_tag, index);
      exp_wb++;
      exp_stall += r2 - r1 + 1;
    end
    step();
    chk("both_hold_req", bus.mem_req, 1'b0);
    chk("both_hold_ready", ready_L2_L1, 1'b0);
    step();
    r1 = cyc;
    wait_ready(r2, line);
    read_L1_L2 = 1'b0;
    if (r2 >= 0) begin
      check_beats(1'b0, tag, index);
      check_line(tag, index, line);
      exp_fill++;
      exp_stall += r2 - r1 + 1;
    end
    step();
    chk("both_ready_once", ready_L2_L1, 1'b0);
    step();

    // Long read latency: requests stay back-to-back
    rv_min = 5; rv_max = 5; tag = 20'h13579; index = 6'd40;
    txn(1'b0, lat);
    chk("b2b_span", g_span, LINE_WORDS - 1);
    chk("ready_after_rv", t_ready, last_rv_cyc + 1);

    // Reset at beat 7 of a fill
    rv_min = 1; rv_max = 1; tag = 20'h2468A; index = 6'd9;
    clear_log();
    read_L1_L2 = 1'b1;
    for (int n = 0; n < 100 && log_addr.size() < 8; n++) step();
    chk("mid_rst_beats", log_addr.size(), 8);
    nrst = 1'b0;
    #1;
    chk("mid_rst_req", bus.mem_req, 1'b0);
    chk("mid_rst_ready", ready_L2_L1, 1'b0);
    read_L1_L2 = 1'b0;
    clear_log();
    pend_due.delete();
    pend_addr.delete();
    last_due = 0;
    exp_fill = 0; exp_wb = 0; exp_stall = 0;
    step();
    step();
    nrst = 1'b1;
    step();

    // Stray rvalid while idle, then a clean fill from beat 0
    stray_req = 1'b1;
    step();
    step();
    txn(1'b0, lat);
    found = 0;
    for (int k = 0; k < LINE_WORDS; k++)
      if (last_line[k*WORD_W +: WORD_W] == 32'hDEAD_BEEF) found++;
    chk("no_stray_word", found, 0);
`ifdef L1I_REFILL_PERF_EN
    chk("perf_fill_after_rst", fill_cnt, 1);
`endif

    // Randomized traffic
    pat_mode = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bit wb;
      wb = 1'($urandom_range(0, 1));
      tag = 20'($urandom);
      wb_tag = 20'($urandom);
      index = 6'($urandom);
      rand_line();
      gnt_mode = int'($urandom_range(0, 2));
      rv_min = 1;
      rv_max = int'($urandom_range(1, 6));
      txn(wb, lat);
    end

`ifdef L1I_REFILL_PERF_EN
    chk("perf_fill", fill_cnt, exp_fill);
    chk("perf_wb", wb_cnt, exp_wb);
    chk("perf_stall", stall_cyc_cnt, exp_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
